// File: rtl/bcd_credit_accum.sv
// BCD coin-credit accumulator. Each accepted coin is added to the credit one BCD digit per
// cycle. The credit register is updated only once, after the last digit, and saturates at
// all-9s with a sticky overflow flag.
module bcd_credit_accum #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coin_valid,
    input  logic [1:0]            coin_code,
    output logic                  coin_ready,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   credit,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned   IW   = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic {StIdle, StAdd} state_e;

    state_e                  state_q;
    logic [DIGITS-1:0][3:0]  credit_q;
    logic [DIGITS-1:0][3:0]  work_q;
    logic [DIGITS-1:0][3:0]  addend_q;
    logic [IW-1:0]           idx_q;
    logic                    carry_q;
    logic                    overflow_q;

    logic [DIGITS-1:0][3:0]  addend_new;
    logic [DIGITS-1:0][3:0]  work_d;
    logic [4:0]              digit_sum;
    logic [3:0]              digit_new;
    logic                    carry_new;

    assign coin_ready = (state_q == StIdle) && !clear;
    assign busy       = (state_q == StAdd);
    assign credit     = credit_q;
    assign overflow   = overflow_q;

    // Decode the coin code into a BCD addend (only digits 0 and 1 are ever nonzero).
    always_comb begin
        addend_new = '0;
        unique case (coin_code)
            2'b00: addend_new[0] = 4'd5;
            2'b01: addend_new[1] = 4'd1;
            2'b10: addend_new[1] = 4'd2;
            2'b11: addend_new[1] = 4'd5;
        endcase
    end

    // One decimal digit add with carry, plus the working register with that digit replaced.
    always_comb begin
        digit_sum = 5'(work_q[idx_q]) + 5'(addend_q[idx_q]) + 5'(carry_q);
        if (digit_sum > 5'd9) begin
            digit_new = 4'(digit_sum - 5'd10);
            carry_new = 1'b1;
        end else begin
            digit_new = digit_sum[3:0];
            carry_new = 1'b0;
        end
        work_d         = work_q;
        work_d[idx_q]  = digit_new;
    end

    // Control FSM and datapath registers; reset beats clear, clear beats coin handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            credit_q   <= '0;
            work_q     <= '0;
            addend_q   <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            // In ADD this aborts the pending coin.
            state_q    <= StIdle;
            credit_q   <= '0;
            overflow_q <= 1'b0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (coin_valid) begin
                        addend_q <= addend_new;
                        work_q   <= credit_q;
                        carry_q  <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= StAdd;
                    end
                end
                StAdd: begin
                    if (idx_q == LAST) begin
                        state_q <= StIdle;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                        if (carry_new) begin
                            credit_q   <= {DIGITS{4'd9}};
                            overflow_q <= 1'b1;
                        end else begin
                            credit_q <= work_d;
                        end
                    end else begin
                        work_q  <= work_d;
                        carry_q <= carry_new;
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
